// File: rtl/fpga_tree_engine.sv
// Pipelined binary decision-tree classifier: one tree level per stage, then a leaf-class lookup.
// The node/leaf table is writable only while the pipeline is completely empty.
module fpga_tree_engine #(
  parameter int NUM_FEATURES = 4,
  parameter int FEAT_W       = 16,
  parameter int DEPTH        = 3,
  parameter int TAG_W        = 8,
  parameter int IDX_W        = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  parameter int ADDR_W       = DEPTH + 1,
  parameter int CFG_W        = IDX_W + FEAT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_FEATURES*FEAT_W-1:0] in_features,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_prediction,
  output logic [DEPTH-1:0]               out_leaf,
  output logic [TAG_W-1:0]               out_tag,
  input  logic                           cfg_we,
  output logic                           cfg_ready,
  input  logic [ADDR_W-1:0]              cfg_addr,
  input  logic [CFG_W-1:0]               cfg_data,
  output logic [31:0]                    pos_count
);

  localparam int NODES = (1 << DEPTH) - 1;
  localparam int LAST  = (1 << (DEPTH + 1)) - 2;
  localparam int TBL   = 1 << ADDR_W;

  // Tables span the full address space so any cfg_addr/node index is in range.
  logic [FEAT_W-1:0] thr  [TBL];
  logic [IDX_W-1:0]  fidx [TBL];
  logic              cls  [TBL];

  logic [DEPTH-1:0]               s_valid;
  logic [ADDR_W-1:0]              s_node [DEPTH];
  logic [NUM_FEATURES*FEAT_W-1:0] s_feat [DEPTH];
  logic [TAG_W-1:0]               s_tag  [DEPTH];
  logic [ADDR_W-1:0]              nxt_node [DEPTH];
  logic [DEPTH-1:0]               go_right;

  logic stall;
  logic accept;
  logic cfg_wr;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall && !cfg_we;
  assign accept    = in_valid && in_ready;
  assign cfg_ready = (s_valid == '0) && !out_valid;
  assign cfg_wr    = cfg_we && cfg_ready;

  // Out-of-range indices select zero, which can never exceed a threshold, so they go left.
  function automatic logic [FEAT_W-1:0] pick(input logic [NUM_FEATURES*FEAT_W-1:0] vec,
                                             input logic [IDX_W-1:0] idx);
    pick = '0;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      if (idx == IDX_W'(f)) pick = vec[f*FEAT_W +: FEAT_W];
    end
  endfunction

  for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
    logic [ADDR_W-1:0]              cur;
    logic [NUM_FEATURES*FEAT_W-1:0] vec;
    if (k == 0) begin : g_root
      assign cur = '0;
      assign vec = in_features;
    end else begin : g_inner
      assign cur = s_node[k-1];
      assign vec = s_feat[k-1];
    end
    assign go_right[k] = pick(vec, fidx[cur]) > thr[cur];
    assign nxt_node[k] = (cur << 1) + ADDR_W'(1) + ADDR_W'(go_right[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid        <= '0;
      out_valid      <= 1'b0;
      out_prediction <= 1'b0;
      out_leaf       <= '0;
      out_tag        <= '0;
      pos_count      <= '0;
      for (int i = 0; i < TBL; i++) begin
        thr[i]  <= '1;
        fidx[i] <= '0;
        cls[i]  <= 1'b0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        s_node[k] <= '0;
        s_feat[k] <= '0;
        s_tag[k]  <= '0;
      end
    end else begin
      if (cfg_wr) begin
        if (int'(cfg_addr) < NODES) begin
          fidx[cfg_addr] <= cfg_data[CFG_W-1:FEAT_W];
          thr[cfg_addr]  <= cfg_data[FEAT_W-1:0];
        end else if (int'(cfg_addr) <= LAST) begin
          cls[cfg_addr] <= cfg_data[0];
        end
      end

      if (!stall) begin
        s_valid[0] <= accept;
        if (accept) begin
          s_node[0] <= nxt_node[0];
          s_feat[0] <= in_features;
          s_tag[0]  <= in_tag;
        end
        for (int k = 1; k < DEPTH; k++) begin
          s_valid[k] <= s_valid[k-1];
          if (s_valid[k-1]) begin
            s_node[k] <= nxt_node[k];
            s_feat[k] <= s_feat[k-1];
            s_tag[k]  <= s_tag[k-1];
          end
        end
        out_valid <= s_valid[DEPTH-1];
        if (s_valid[DEPTH-1]) begin
          out_prediction <= cls[s_node[DEPTH-1]];
          out_leaf       <= DEPTH'(s_node[DEPTH-1] - ADDR_W'(NODES));
          out_tag        <= s_tag[DEPTH-1];
        end
      end

      if (out_valid && out_ready && out_prediction && (pos_count != '1))
        pos_count <= pos_count + 32'd1;
    end
  end

endmodule
